sram_access_ctrl: RTL

Sequencer that turns single-word AVR read/write requests into SRAM cycles in the CPLD. It drives SRAM address and strobes plus the `sram_dir` select for the bidirectional bus stage downstream, latches read data and returns a one-cycle acknowledge. Wait states are fixed at elaboration.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_wait_counter.sv | 31 +++
 rtl/sram_access_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM access sequencer and the downstream bus stage:
// FSM state encoding and the bus direction codes.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic DIR_AVR_TO_SRAM = 1'b0;
    localparam logic DIR_SRAM_TO_AVR = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: loaded on SETUP entry, decremented through ACCESS,
// zero flag marks the last strobe-active cycle.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    // Loading WAIT_CYCLES-1 gives exactly WAIT_CYCLES ACCESS cycles, the last one at zero.
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-word AVR-to-SRAM access sequencer: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE.
// All SRAM-side outputs, ack and rdata are registered from the next-state decode.
module sram_access_ctrl
    import sram_pkg::*;
#(
    parameter int AWIDTH      = 19,
    parameter int DWIDTH      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic              ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              busy,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_wdata,
    input  logic [DWIDTH-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_dir
);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("sram_access_ctrl: WAIT_CYCLES must be at least 1");
        end
    endgenerate

    state_t r_state;
    state_t w_state_next;

    logic              r_we;
    logic              r_ack;
    logic [DWIDTH-1:0] r_rdata;
    logic [AWIDTH-1:0] r_sram_addr;
    logic [DWIDTH-1:0] r_sram_wdata;
    logic              r_sram_ce_n;
    logic              r_sram_oe_n;
    logic              r_sram_we_n;
    logic              r_sram_dir;

    logic w_accept;
    logic w_cnt_dec;
    logic w_cnt_zero;
    logic w_we_next;
    logic w_strobe_next;
    logic w_capture;
    logic w_ce_n_next;
    logic w_oe_n_next;
    logic w_we_n_next;
    logic w_dir_next;
    logic w_ack_next;

    assign w_accept  = (r_state == ST_IDLE) && req;
    assign w_cnt_dec = (r_state == ST_ACCESS) && !w_cnt_zero;
    assign w_capture = (r_state == ST_ACCESS) && w_cnt_zero && !r_we;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_accept),
        .i_dec (w_cnt_dec),
        .o_zero(w_cnt_zero)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (req) w_state_next = ST_SETUP;
            ST_SETUP:  w_state_next = ST_ACCESS;
            ST_ACCESS: if (w_cnt_zero) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Output decode looks at the state being entered so every strobe is a plain flop.
    always_comb begin
        w_we_next     = w_accept ? we : r_we;
        w_strobe_next = (w_state_next == ST_SETUP) || (w_state_next == ST_ACCESS);
        w_ce_n_next   = !(w_strobe_next || (w_we_next && (w_state_next == ST_DONE)));
        w_oe_n_next   = !(w_strobe_next && !w_we_next);
        w_we_n_next   = !(w_we_next && (w_state_next == ST_ACCESS));
        w_dir_next    = (w_we_next && (w_state_next != ST_IDLE)) ? DIR_AVR_TO_SRAM
                                                                 : DIR_SRAM_TO_AVR;
        w_ack_next    = (w_state_next == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_ce_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
            r_sram_we_n  <= 1'b1;
            r_sram_dir   <= DIR_SRAM_TO_AVR;
        end else begin
            r_state     <= w_state_next;
            r_ack       <= w_ack_next;
            r_sram_ce_n <= w_ce_n_next;
            r_sram_oe_n <= w_oe_n_next;
            r_sram_we_n <= w_we_n_next;
            r_sram_dir  <= w_dir_next;
            if (w_accept) begin
                r_we         <= we;
                r_sram_addr  <= addr;
                r_sram_wdata <= wdata;
            end
            if (w_capture) begin
                r_rdata <= sram_rdata;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign sram_ce_n  = r_sram_ce_n;
    assign sram_oe_n  = r_sram_oe_n;
    assign sram_we_n  = r_sram_we_n;
    assign sram_dir   = r_sram_dir;

endmodule
